frame_sequencer: RTL and testbench
==================================

// Module: frame_sequencer
// PURPOSE
//  Next-generation frame manager. On each frame request it latches the target time and sweeps
//  the channel address space into one of N frame banks, several channels per cycle. It then
//  commits that bank to the output driver and raises a one-cycle done request.
//  Adds the following over the single-bank manager: multi-lane stride, bank rotation, stall,
//  abort, one-deep request queuing and overrun flagging.
// PARAMETERS
//  c_ledboards  30                 number of LED boards, 32 channels each
//  c_max_time   1024               fade-time range; c_time_w = $clog2(c_max_time)
//  c_lanes      1                  channels written per cycle; must divide c_channels
//  c_buffers    2                  frame banks; c_bank_w = max(1, $clog2(c_buffers))
//  c_channels   c_ledboards*32     derived; c_addr_w = $clog2(c_channels)
// PORTS
//  i_clk          in   1         clock; all state updates on rising edge
//  i_rst          in   1         synchronous reset, active-high
//  i_drq          in   1         frame request, sampled every cycle
//  i_target_time  in   c_time_w  fade time belonging to the request, valid with i_drq
//  i_hold         in   1         stall: no address advance and no write this cycle
//  i_abort        in   1         cancel the copy in progress; no commit
//  o_addr         out  c_addr_w  base channel address; the lane k write goes to o_addr+k
//  o_wbank        out  c_bank_w  bank being written
//  o_rbank        out  c_bank_w  last committed bank, read by the output driver
//  o_start_time   out  c_time_w  latched target time of the current/last frame
//  o_wen          out  1         write strobe
//  o_drq          out  1         one-cycle pulse when a frame is committed
//  o_busy         out  1         high in S_COPY and S_FLUSH
//  o_overrun      out  1         one-cycle pulse when a request is dropped
// BEHAVIOUR
//  Reset: state=S_WAIT, o_addr=0, o_wbank=1 (0 if c_buffers=1), o_rbank=0, o_start_time=0,
//   o_wen=0, o_drq=0, o_busy=0, o_overrun=0, pending=0. Reset mid-copy discards the frame
//   and the pending request.
//  S_WAIT: o_addr held at 0. If i_drq or pending: latch i_target_time (or pend_time), clear
//   pending, go to S_COPY.
//  S_COPY: o_wen = !i_hold (combinational, no registered delay).
//   - If !i_hold: at last address (c_channels-c_lanes), go to S_FLUSH; else o_addr += c_lanes.
//   - If i_hold: state and address unchanged.
//   - First write occurs the cycle after i_drq is sampled.
//   - Unstalled frame length is exactly c_channels/c_lanes o_wen cycles.
//  S_FLUSH (1 cycle): o_wen=0, o_drq=1. At its end:
//   - o_rbank <= o_wbank
//   - o_wbank <= (o_wbank+1) mod c_buffers, skipping the new o_rbank when c_buffers>1
//   - go to S_WAIT.
//   - With c_buffers=1, o_wbank = o_rbank = 0 always.
//  Latency: i_drq at edge N -> o_drq high in cycle N+1+c_channels/c_lanes+holds.
//  Requests while busy: the first one is stored (pending=1, pend_time=i_target_time).
//   - A further request while pending=1 is dropped: o_overrun pulses and pend_time keeps
//     the older value.
//   - A request in the S_FLUSH cycle counts as busy.
//  i_abort in S_COPY or S_FLUSH: return to S_WAIT next cycle, o_addr=0, no o_drq, banks
//   unchanged, pending kept.
//   - Abort wins over hold and over the last-address transition.
//   - Ignored in S_WAIT.
//  i_drq and i_abort in the same busy cycle: abort, and the request becomes pending.
//  o_start_time changes only on latch; it stays stable through S_FLUSH for the consumer.
//  Address arithmetic is c_addr_w wide and never wraps: the S_COPY exit prevents overflow.
// TESTING
//  1 c_ledboards=1, c_lanes=4, c_buffers=2. drq with time=100 ->
//    o_addr 0,4,...,28 over 8 o_wen cycles, then o_drq pulse, o_rbank 0->1, o_wbank 1->0,
//    o_start_time=100.
//  2 Same config; hold for 3 cycles at addr=12 -> o_wen low 3 cycles, addr stays 12,
//    o_drq exactly 11 cycles after first write.
//  3 Abort at addr=16 -> no o_drq, o_rbank unchanged, o_busy low next cycle.
//    A new drq restarts at addr 0.
//  4 drq(time=5) then drq(time=7) mid-copy -> second frame starts the cycle after flush
//    with o_start_time=7. A third drq(time=9) during the first frame -> o_overrun pulse,
//    second frame keeps time 7.
//  5 c_buffers=3, 4 frames -> o_rbank sequence 0,1,2,0, with o_wbank never equal to o_rbank.
//  6 Reset asserted mid-copy with pending set -> all outputs at reset values next cycle,
//    no o_drq, no queued frame.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame sequencer: sweeps the channel space into a rotating set of frame banks
// on each request, then commits the bank to the output driver with a done pulse.
module frame_sequencer #(
    parameter int unsigned  c_ledboards = 30,
    parameter int unsigned  c_max_time  = 1024,
    parameter int unsigned  c_lanes     = 1,
    parameter int unsigned  c_buffers   = 2,
    localparam int unsigned c_channels  = c_ledboards * 32,
    localparam int unsigned c_time_w    = $clog2(c_max_time),
    localparam int unsigned c_addr_w    = $clog2(c_channels),
    localparam int unsigned c_bank_w    = (c_buffers > 1) ? $clog2(c_buffers) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_drq,
    input  logic [c_time_w-1:0] i_target_time,
    input  logic                i_hold,
    input  logic                i_abort,
    output logic [c_addr_w-1:0] o_addr,
    output logic [c_bank_w-1:0] o_wbank,
    output logic [c_bank_w-1:0] o_rbank,
    output logic [c_time_w-1:0] o_start_time,
    output logic                o_wen,
    output logic                o_drq,
    output logic                o_busy,
    output logic                o_overrun
);

    localparam logic [c_addr_w-1:0] c_last      = c_addr_w'(c_channels - c_lanes);
    localparam logic [c_addr_w-1:0] c_step      = c_addr_w'(c_lanes);
    localparam logic [c_bank_w-1:0] c_bank_max  = c_bank_w'(c_buffers - 1);
    localparam logic [c_bank_w-1:0] c_wbank_rst = (c_buffers > 1) ? c_bank_w'(1) : c_bank_w'(0);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COPY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_addr_w-1:0] r_addr;
    logic [c_bank_w-1:0] r_wbank;
    logic [c_bank_w-1:0] r_rbank;
    logic [c_bank_w-1:0] w_wbank_next;
    logic [c_time_w-1:0] r_start_time;
    logic [c_time_w-1:0] r_pend_time;
    logic                r_pending;
    logic                r_overrun;
    logic                w_busy;

    // The committed bank becomes the old write bank, so +1 mod N never lands on it.
    assign w_wbank_next = (r_wbank >= c_bank_max) ? c_bank_w'(0) : r_wbank + c_bank_w'(1);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_WAIT;
        else       r_state <= w_state_next;
    end

    // Next-state logic; abort wins over hold and over the last-address exit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT:  if (i_drq || r_pending) w_state_next = S_COPY;
            S_COPY: begin
                if (i_abort)                        w_state_next = S_WAIT;
                else if (!i_hold && r_addr == c_last) w_state_next = S_FLUSH;
            end
            S_FLUSH: w_state_next = S_WAIT;
            default: w_state_next = S_WAIT;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_wen  = 1'b0;
        o_drq  = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            S_COPY: begin
                o_wen  = !i_hold;
                w_busy = 1'b1;
            end
            S_FLUSH: begin
                o_drq  = !i_abort;
                w_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Address sweep, bank rotation, time latch and one-deep request queue
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr       <= '0;
            r_wbank      <= c_wbank_rst;
            r_rbank      <= '0;
            r_start_time <= '0;
            r_pend_time  <= '0;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    r_addr <= '0;
                    if (r_pending) begin
                        r_start_time <= r_pend_time;
                        r_pending    <= i_drq;
                        if (i_drq) r_pend_time <= i_target_time;
                    end else if (i_drq) begin
                        r_start_time <= i_target_time;
                    end
                end
                S_COPY: begin
                    if (i_abort)                          r_addr <= '0;
                    else if (!i_hold && r_addr != c_last) r_addr <= r_addr + c_step;
                end
                S_FLUSH: begin
                    r_addr <= '0;
                    if (!i_abort) begin
                        r_rbank <= r_wbank;
                        r_wbank <= w_wbank_next;
                    end
                end
                default: r_addr <= '0;
            endcase
            if (w_busy && i_drq) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending   <= 1'b1;
                    r_pend_time <= i_target_time;
                end
            end
        end
    end

    assign o_addr       = r_addr;
    assign o_wbank      = r_wbank;
    assign o_rbank      = r_rbank;
    assign o_start_time = r_start_time;
    assign o_busy       = w_busy;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench: two sequencers (2 and 3 banks, 32 channels, 4 lanes) driven
// with directed frames; a negedge monitor pops expected writes and commits.
module tb_frame_sequencer;

    typedef struct {
        int t;
        int wb;
        int rb;
        int wa;
    } commit_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_drq, a_hold, a_abort;
    logic [9:0] a_time;
    logic [4:0] a_addr;
    logic [0:0] a_wbank, a_rbank;
    logic [9:0] a_start;
    logic       a_wen, a_odrq, a_busy, a_ovr;

    logic       b_drq, b_hold, b_abort;
    logic [9:0] b_time;
    logic [4:0] b_addr;
    logic [1:0] b_wbank, b_rbank;
    logic [9:0] b_start;
    logic       b_wen, b_odrq, b_busy, b_ovr;

    frame_sequencer #(.c_ledboards(1), .c_max_time(1024), .c_lanes(4), .c_buffers(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_drq(a_drq), .i_target_time(a_time),
        .i_hold(a_hold), .i_abort(a_abort), .o_addr(a_addr), .o_wbank(a_wbank),
        .o_rbank(a_rbank), .o_start_time(a_start), .o_wen(a_wen), .o_drq(a_odrq),
        .o_busy(a_busy), .o_overrun(a_ovr)
    );

    frame_sequencer #(.c_ledboards(1), .c_max_time(1024), .c_lanes(4), .c_buffers(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_drq(b_drq), .i_target_time(b_time),
        .i_hold(b_hold), .i_abort(b_abort), .o_addr(b_addr), .o_wbank(b_wbank),
        .o_rbank(b_rbank), .o_start_time(b_start), .o_wen(b_wen), .o_drq(b_odrq),
        .o_busy(b_busy), .o_overrun(b_ovr)
    );

    int      n_checks = 0;
    int      n_errors = 0;
    int      qaddr[$];
    commit_t qa[$];
    commit_t qb[$];
    bit      mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic empty_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual unexpected-output required none", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_addrs(input int upto);
        for (int a = 0; a <= upto; a += 4) qaddr.push_back(a);
    endtask

    task automatic push_frame(input int t, input int wb, input int rb, input int wa);
        commit_t c;
        push_addrs(28);
        c.t = t; c.wb = wb; c.rb = rb; c.wa = wa;
        qa.push_back(c);
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!a_odrq && n < 40) begin
            tick;
            n++;
        end
    endtask

    // Monitor: pops expected writes and commits whenever the DUTs present them
    commit_t a_pe, b_pe;
    bit      a_post = 1'b0, b_post = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_post) begin
                chk("a_rbank_after_commit", int'(a_rbank), a_pe.wb);
                chk("a_wbank_after_commit", int'(a_wbank), a_pe.wa);
                a_post = 1'b0;
            end
            if (a_wen) begin
                if (qaddr.size() == 0) empty_fail("a_wen");
                else chk("a_addr", int'(a_addr), qaddr.pop_front());
            end
            if (a_odrq) begin
                if (qa.size() == 0) empty_fail("a_drq");
                else begin
                    a_pe = qa.pop_front();
                    chk("a_start_time", int'(a_start), a_pe.t);
                    chk("a_wbank_commit", int'(a_wbank), a_pe.wb);
                    chk("a_rbank_before", int'(a_rbank), a_pe.rb);
                    a_post = 1'b1;
                end
            end
            if (b_post) begin
                chk("b_rbank_after_commit", int'(b_rbank), b_pe.wb);
                chk("b_wbank_after_commit", int'(b_wbank), b_pe.wa);
                b_post = 1'b0;
            end
            if (b_wen) chk("b_banks_distinct", int'(b_wbank != b_rbank), 1);
            if (b_odrq) begin
                if (qb.size() == 0) empty_fail("b_drq");
                else begin
                    b_pe = qb.pop_front();
                    chk("b_start_time", int'(b_start), b_pe.t);
                    chk("b_wbank_commit", int'(b_wbank), b_pe.wb);
                    chk("b_rbank_before", int'(b_rbank), b_pe.rb);
                    b_post = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // Frame table for the 3-bank sequencer: time, committed wbank, rbank before, wbank after
    int b_tab[4][4] = '{'{10, 1, 0, 2}, '{20, 2, 1, 0}, '{30, 0, 2, 1}, '{40, 1, 0, 2}};

    initial begin
        int n;
        commit_t c;
        rst = 1'b1;
        a_drq = 1'b0; a_hold = 1'b0; a_abort = 1'b0; a_time = '0;
        b_drq = 1'b0; b_hold = 1'b0; b_abort = 1'b0; b_time = '0;
        tick; tick;
        chk("rst_addr", int'(a_addr), 0);
        chk("rst_wbank", int'(a_wbank), 1);
        chk("rst_rbank", int'(a_rbank), 0);
        chk("rst_start", int'(a_start), 0);
        chk("rst_wen", int'(a_wen), 0);
        chk("rst_drq", int'(a_odrq), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_ovr", int'(a_ovr), 0);
        chk("rst_b_wbank", int'(b_wbank), 1);
        rst = 1'b0;
        mon_en = 1'b1;
        tick;

        // Plain frame
        a_drq = 1'b1; a_time = 10'd100;
        push_frame(100, 1, 0, 0);
        tick;
        a_drq = 1'b0;
        chk("t1_first_addr", int'(a_addr), 0);
        chk("t1_first_wen", int'(a_wen), 1);
        wait_a(n);
        chk("t1_latency", n, 8);
        tick;
        chk("t1_busy_after", int'(a_busy), 0);

        // Three-cycle hold at address 12
        a_drq = 1'b1; a_time = 10'd200;
        push_frame(200, 0, 1, 1);
        tick;
        a_drq = 1'b0;
        tick; tick; tick;
        chk("t2_addr_before_hold", int'(a_addr), 12);
        a_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_hold_wen", int'(a_wen), 0);
            chk("t2_hold_addr", int'(a_addr), 12);
            tick;
        end
        a_hold = 1'b0;
        wait_a(n);
        chk("t2_latency", 6 + n, 11);
        tick;

        // Abort at address 16, then restart
        a_drq = 1'b1; a_time = 10'd300;
        push_addrs(16);
        tick;
        a_drq = 1'b0;
        tick; tick; tick; tick;
        chk("t3_addr_before_abort", int'(a_addr), 16);
        a_abort = 1'b1;
        tick;
        a_abort = 1'b0;
        chk("t3_busy_after_abort", int'(a_busy), 0);
        chk("t3_addr_after_abort", int'(a_addr), 0);
        chk("t3_rbank_kept", int'(a_rbank), 0);
        chk("t3_wbank_kept", int'(a_wbank), 1);
        tick;
        chk("t3_idle", int'(a_busy), 0);
        a_drq = 1'b1; a_time = 10'd400;
        push_frame(400, 1, 0, 0);
        tick;
        a_drq = 1'b0;
        chk("t3_restart_addr", int'(a_addr), 0);
        wait_a(n);
        chk("t3_latency", n, 8);
        tick;

        // Queued request and overrun
        a_drq = 1'b1; a_time = 10'd5;
        push_frame(5, 0, 1, 1);
        push_frame(7, 1, 0, 0);
        tick;
        a_drq = 1'b0;
        tick; tick;
        a_drq = 1'b1; a_time = 10'd7;
        tick;
        a_drq = 1'b0;
        tick;
        a_drq = 1'b1; a_time = 10'd9;
        tick;
        a_drq = 1'b0;
        chk("t4_overrun_pulse", int'(a_ovr), 1);
        tick;
        chk("t4_overrun_end", int'(a_ovr), 0);
        wait_a(n);
        chk("t4_f1_latency", 6 + n, 8);
        tick;
        chk("t4_gap_start", int'(a_start), 5);
        tick;
        chk("t4_f2_start", int'(a_start), 7);
        chk("t4_f2_addr", int'(a_addr), 0);
        chk("t4_f2_busy", int'(a_busy), 1);
        wait_a(n);
        chk("t4_f2_latency", n, 8);
        tick; tick; tick;
        chk("t4_no_third", int'(a_busy), 0);

        // Bank rotation with three banks
        for (int f = 0; f < 4; f++) begin
            c.t = b_tab[f][0]; c.wb = b_tab[f][1]; c.rb = b_tab[f][2]; c.wa = b_tab[f][3];
            qb.push_back(c);
            b_drq = 1'b1; b_time = 10'(b_tab[f][0]);
            tick;
            b_drq = 1'b0;
            n = 0;
            while (!b_odrq && n < 40) begin
                tick;
                n++;
            end
            chk("t5_latency", n, 8);
            tick;
        end
        tick;
        chk("t5_final_rbank", int'(b_rbank), 1);

        // Reset mid-copy with a request pending
        a_drq = 1'b1; a_time = 10'd50;
        push_addrs(8);
        tick;
        a_drq = 1'b0;
        tick;
        a_drq = 1'b1; a_time = 10'd60;
        tick;
        a_drq = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_addr", int'(a_addr), 0);
        chk("t6_wbank", int'(a_wbank), 1);
        chk("t6_rbank", int'(a_rbank), 0);
        chk("t6_start", int'(a_start), 0);
        chk("t6_wen", int'(a_wen), 0);
        chk("t6_drq", int'(a_odrq), 0);
        chk("t6_busy", int'(a_busy), 0);
        repeat (12) tick;
        chk("t6_no_queued_frame", int'(a_busy), 0);
        chk("t6_start_kept", int'(a_start), 0);

        chk("end_addr_q", qaddr.size(), 0);
        chk("end_a_commit_q", qa.size(), 0);
        chk("end_b_commit_q", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
